// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - CPU data SRAM request/response bundle
// master: en, wen, addr, wdata out; rdata in (core side)
// slave : en, wen, addr, wdata in; rdata out (responder side)
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: word RAM plus LED/switch/timer MMIO window
// clk, rst      : single clock, synchronous active-high reset
// bus           : data SRAM slave port (en, wen, addr, wdata in; rdata out, one-cycle registered)
// switch        : asynchronous board switches, two-flop synchronized
// led           : LED register bits [15:0]
// timer_int     : level interrupt, timer reached compare and not yet cleared
module data_sram_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'h1faf
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_responder_if.slave  bus,
    input  logic [7:0]            switch,
    output logic [15:0]           led,
    output logic                  timer_int
);

    localparam int DEPTH = 1 << RAM_AW;

    logic [31:0] mem [DEPTH];

    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [31:0] timer;
    logic [31:0] compare;
    logic        pending;
    logic [15:0] led_reg;
    logic [31:0] rdata_q;
    logic [31:0] mmio_rdata;

    logic              is_mmio;
    logic [RAM_AW-1:0] word_idx;
    logic [13:0]       reg_sel;
    logic              req;
    logic              wr;
    logic              ram_wr;
    logic              led_wr;
    logic              timer_wr;
    logic              compare_wr;
    logic              status_clr;
    logic              match;
    logic              unused_addr;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    assign is_mmio     = (bus.addr[31:16] == MMIO_HI);
    assign word_idx    = bus.addr[RAM_AW+1:2];
    assign reg_sel     = bus.addr[15:2];
    assign unused_addr = ^bus.addr[1:0];

    // A request coincident with reset is dropped entirely.
    assign req        = bus.en && !rst;
    assign wr         = req && (bus.wen != 4'b0000);
    assign ram_wr     = wr && !is_mmio;
    assign led_wr     = wr && is_mmio && (reg_sel == 14'd0);
    assign timer_wr   = wr && is_mmio && (reg_sel == 14'd2);
    assign compare_wr = wr && is_mmio && (reg_sel == 14'd3);
    assign status_clr = req && is_mmio && (reg_sel == 14'd4) && bus.wen[0] && bus.wdata[0];

    // Compare against registered values, so a COMPARE write only affects the next cycle.
    assign match = (timer == compare) && (compare != 32'd0);

    always_comb begin
        mmio_rdata = 32'd0;
        case (reg_sel)
            14'd0:   mmio_rdata = {16'd0, led_reg};
            14'd1:   mmio_rdata = {24'd0, sw_sync};
            14'd2:   mmio_rdata = timer;
            14'd3:   mmio_rdata = compare;
            14'd4:   mmio_rdata = {31'd0, pending};
            default: mmio_rdata = 32'd0;
        endcase
    end

    // RAM contents are not reset; read-first comes from rdata_q sampling the old word.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (bus.en) begin
            rdata_q <= is_mmio ? mmio_rdata : mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 8'd0;
            sw_sync <= 8'd0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= 16'd0;
        end else if (led_wr) begin
            if (bus.wen[0]) led_reg[7:0]  <= bus.wdata[7:0];
            if (bus.wen[1]) led_reg[15:8] <= bus.wdata[15:8];
        end
    end

    // A TIMER write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 32'd0;
        end else if (timer_wr) begin
            timer <= lane_merge(timer, bus.wdata, bus.wen);
        end else begin
            timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= 32'd0;
        end else if (compare_wr) begin
            compare <= lane_merge(compare, bus.wdata, bus.wen);
        end
    end

    // A new match outranks a simultaneous STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end else if (status_clr) begin
            pending <= 1'b0;
        end
    end

    assign bus.rdata = rdata_q;
    assign led       = led_reg;
    assign timer_int = pending;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized and directed bench for data_sram_responder
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        timer_int;

    data_sram_responder_if bus();

    data_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switch    (switch),
        .led       (led),
        .timer_int (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Timer is kept as a base value plus elapsed edges.
    logic [31:0] m_ram [int];
    logic [31:0] m_rdata;
    bit          m_rdata_known;
    logic [15:0] m_led;
    logic [31:0] m_compare;
    logic [31:0] m_tbase;
    int          m_tedge;
    int          m_edge = 0;
    bit          m_pending;
    logic [7:0]  m_sw_delay [2];
    bit          m_valid = 0;

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur_t;
        logic [31:0] off;
        int          idx;
        bit          mmio;
        bit          hit;
        cur_t = m_tbase + 32'(m_edge - m_tedge);
        m_edge++;
        if (rst) begin
            m_rdata = 32'd0; m_rdata_known = 1; m_led = 16'd0; m_compare = 32'd0;
            m_tbase = 32'd0; m_tedge = m_edge; m_pending = 0;
            m_sw_delay[0] = 8'd0; m_sw_delay[1] = 8'd0;
            m_valid = 1;
        end else begin
            hit  = (cur_t == m_compare) && (m_compare != 0);
            mmio = (bus.addr[31:16] == 16'h1faf);
            off  = {16'd0, bus.addr[15:0]} & 32'hFFFC;
            idx  = int'((bus.addr >> 2) & 32'hFFF);
            if (bus.en) begin
                if (mmio) begin
                    m_rdata_known = 1;
                    case (off)
                        32'h0:   m_rdata = {16'd0, m_led};
                        32'h4:   m_rdata = {24'd0, m_sw_delay[1]};
                        32'h8:   m_rdata = cur_t;
                        32'hC:   m_rdata = m_compare;
                        32'h10:  m_rdata = {31'd0, m_pending};
                        default: m_rdata = 32'd0;
                    endcase
                    if (off == 32'h0) m_led = m_merge({16'd0, m_led}, bus.wdata, bus.wen & 4'b0011);
                    if (off == 32'hC) m_compare = m_merge(m_compare, bus.wdata, bus.wen);
                    if (off == 32'h8 && bus.wen != 0) begin
                        m_tbase = m_merge(cur_t, bus.wdata, bus.wen);
                        m_tedge = m_edge;
                    end
                    if (off == 32'h10 && bus.wen[0] && bus.wdata[0] && !hit) m_pending = 0;
                end else begin
                    m_rdata_known = m_ram.exists(idx);
                    if (m_rdata_known) m_rdata = m_ram[idx];
                    if (bus.wen == 4'hF) m_ram[idx] = bus.wdata;
                    else if (bus.wen != 0 && m_ram.exists(idx)) m_ram[idx] = m_merge(m_ram[idx], bus.wdata, bus.wen);
                    else if (bus.wen != 0) m_ram.delete(idx);
                end
            end
            if (hit) m_pending = 1;
            m_sw_delay[1] = m_sw_delay[0];
            m_sw_delay[0] = switch;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_rdata_known) check("rdata", bus.rdata, m_rdata);
            check("led", {16'd0, led}, {16'd0, m_led});
            check("timer_int", {31'd0, timer_int}, {31'd0, m_pending});
        end
    end

    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0; bus.wen = 4'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 4'b0, 32'd0, 32'd0);
    endtask

    localparam logic [31:0] LED_A = 32'h1faf0000;
    localparam logic [31:0] SW_A  = 32'h1faf0004;
    localparam logic [31:0] TMR_A = 32'h1faf0008;
    localparam logic [31:0] CMP_A = 32'h1faf000C;
    localparam logic [31:0] STS_A = 32'h1faf0010;

    initial begin
        logic [31:0] offs [7];
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] hi;
        logic [3:0]  w;
        logic [3:0]  ix;
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20};

        rst = 1'b1; switch = 8'd0;
        bus.en = 1'b0; bus.wen = 4'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        idle(2);
        rst = 1'b0;
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_led", {16'd0, led}, 32'd0);
        check("reset_int", {31'd0, timer_int}, 32'd0);

        // RAM byte lanes
        req(1, 4'b1111, 32'h100, 32'h11223344);
        req(1, 4'b0010, 32'h100, 32'h0000AA00);
        req(1, 4'b0000, 32'h100, 32'd0);
        check("ram_bytes", bus.rdata, 32'h1122AA44);

        // read-first and hold
        req(1, 4'b1111, 32'h4, 32'h0);
        req(1, 4'b1111, 32'h4, 32'hDEADBEEF);
        check("read_first", bus.rdata, 32'h0);
        req(1, 4'b0000, 32'h4, 32'd0);
        check("next_read", bus.rdata, 32'hDEADBEEF);
        idle(3);
        check("rdata_hold", bus.rdata, 32'hDEADBEEF);

        // MMIO
        req(1, 4'b1111, LED_A, 32'hFFFF1234);
        check("led_write", {16'd0, led}, 32'h1234);
        req(1, 4'b0000, LED_A, 32'd0);
        check("led_read", bus.rdata, 32'h00001234);
        switch = 8'hA5;
        idle(2);
        req(1, 4'b0000, SW_A, 32'd0);
        check("switch_read", bus.rdata, 32'h000000A5);
        req(1, 4'b0000, 32'h1faf0020, 32'd0);
        check("hole_read", bus.rdata, 32'd0);

        // timer interrupt
        req(1, 4'b1111, TMR_A, 32'h00100000);
        req(1, 4'b1111, CMP_A, 32'd20);
        req(1, 4'b1111, TMR_A, 32'd10);
        idle(10);
        check("int_before", {31'd0, timer_int}, 32'd0);
        idle(1);
        check("int_rise", {31'd0, timer_int}, 32'd1);
        req(1, 4'b0001, STS_A, 32'd1);
        check("int_clear", {31'd0, timer_int}, 32'd0);
        req(1, 4'b1111, CMP_A, 32'd0);
        req(1, 4'b1111, TMR_A, 32'hFFFFFFFE);
        idle(5);
        check("cmp0_wrap", {31'd0, timer_int}, 32'd0);

        // collisions
        req(1, 4'b1111, CMP_A, 32'd50);
        req(1, 4'b1111, TMR_A, 32'd40);
        idle(10);
        req(1, 4'b0001, STS_A, 32'd1);
        check("set_wins", {31'd0, timer_int}, 32'd1);
        req(1, 4'b0001, STS_A, 32'd1);
        check("clear_after", {31'd0, timer_int}, 32'd0);
        req(1, 4'b1111, TMR_A, 32'h1000);
        idle(3);
        req(1, 4'b0000, TMR_A, 32'd0);
        check("timer_load", bus.rdata, 32'h1003);

        // reset mid-operation
        req(1, 4'b1111, 32'h200, 32'hCAFEF00D);
        rst = 1'b1;
        req(1, 4'b1111, LED_A, 32'hFFFF5678);
        rst = 1'b0;
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        req(1, 4'b0000, TMR_A, 32'd0);
        check("rst_timer", bus.rdata, 32'd0);
        req(1, 4'b0000, 32'h200, 32'd0);
        check("ram_kept", bus.rdata, 32'hCAFEF00D);

        // randomized traffic
        for (int i = 0; i < 16; i++) req(1, 4'b1111, 32'(i * 4), $urandom);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
            hi = $urandom;
            ix = 4'($urandom);
            d  = $urandom;
            w  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                if (hi[31:16] == 16'h1faf) hi[31:16] = 16'h0000;
                a = {hi[31:14], 8'd0, ix, hi[1:0]};
            end else begin
                a = 32'h1faf0000 | offs[$urandom_range(0, 6)] | {30'd0, hi[1:0]};
                if ($urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 40));
            end
            req($urandom_range(0, 3) != 0, w, a, d);
        end
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
